alu4_sched: RTL
===============

# alu4_sched

Round-robin scheduler sharing one 4-bit ALU among NREQ requesters. Each requester submits an opcode, two 4-bit operands and a carry-in over a valid/ready handshake. The block grants one request at a time, latches it, evaluates it on an internal ALU core, and returns a registered result tagged with the requester index over a second valid/ready handshake. It sits between the instruction-level control of the NPC and the shared 4-bit arithmetic datapath.

## Interface
- NREQ, 4, number of requesters; legal range 2..8
- IDW, $clog2(NREQ), requester index width (derived, not overridden)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; at most one bit high
- req_op  in  3*NREQ  opcode of requester i at [3i+2:3i]
- req_a, req_b  in  4*NREQ  operands of requester i at [4i+3:4i]
- req_cin  in  NREQ  carry-in per requester
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  IDW  index of the requester that issued the result
- rsp_result  out  4  ALU result
- rsp_zero, rsp_overflow, rsp_carry, rsp_size  out  1 each  ALU flags

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: req_ready is one-hot on the round-robin winner among req_valid bits, or all-zero if none are valid. A handshake (valid & ready) latches op/a/b/cin and the index, updates last_grant to the winner, and moves to EXEC.
- Round-robin rule: search starts at last_grant+1 mod NREQ. last_grant resets to NREQ-1, so requester 0 has priority first.
- EXEC: the ALU core evaluates the latched operands. Result and flags are registered. The FSM moves to RESP. req_ready is all-zero.
- RESP: rsp_valid=1 and outputs are held stable. When rsp_ready=1 the FSM returns to IDLE. No new grant is issued in the same cycle.
- Requesters hold their payload stable while valid is high and ready is low. A request whose valid drops before it is granted is simply not served.
- ALU opcodes (Y = 4-bit result; overflow and carry are 0 unless stated):
  - 000 add: {carry,Y}=a+b+cin; overflow = a[3]==b[3] && Y[3]!=a[3].
  - 001 sub: Y=a+~b+1, cin ignored; carry = carry-out (1 = no borrow); overflow = a[3]!=b[3] && Y[3]!=a[3].
  - 010 not: Y=~a.
  - 011 and, 100 or, 101 xor: bitwise.
  - 110 signed compare: Y and flags as sub; size=1 iff a>b (signed); equal gives 0.
  - 111 equality: Y and flags as sub; size=1 iff a==b.
- Flag rules: zero = (Y==0) for all ops. size=0 for ops 000..101.

## Timing
- Reset values: state IDLE, last_grant NREQ-1, req_ready 0, rsp_valid 0, rsp_id 0, rsp_result 0, all flags 0.
- Latency: handshake in cycle N; EXEC in N+1; rsp_valid high from N+2.
- Throughput: one result per 3 cycles when rsp_ready is held at 1.
- rsp_ready held at 0 stalls indefinitely in RESP with outputs frozen, and no requests are accepted.
- Reset asserted mid-operation (EXEC or RESP) discards the in-flight operation. No response is produced for it.
- req_ready depends combinationally on req_valid and state only, never on rsp_ready.

## Structure
- Shared package alu4_pkg: opcode localparams (ALU_ADD..ALU_EQ) and the FSM state enum.
- Sub-module alu4_core: purely combinational, with inputs op/a/b/cin and outputs result/zero/overflow/carry/size. It is instantiated once inside alu4_sched.

## Test plan
- Reset then a single request: req0 op=000, a=7, b=1, cin=0 -> at N+2 rsp_id=0, result=8, overflow=1, carry=0, zero=0.
- Subtract/compare: op=110, a=4'b1110 (-2), b=1 -> result=4'b1101, size=0; op=111, a=b=5 -> result=0, zero=1, size=1, carry=1.
- Fairness: all four requesters held valid -> grants in order 0,1,2,3,0. No requester is granted twice while another is waiting.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp outputs stable, req_ready all 0; rsp_ready=1 -> IDLE next cycle.
- Reset mid-EXEC: assert rst in EXEC -> rsp_valid stays 0, last_grant=NREQ-1, and the next grant goes to requester 0 when multiple requesters are valid.
- Logic ops: op=011/100/101/010 with a=4'b1100, b=4'b1010 -> 1000/1110/0110/0011, with overflow=carry=size=0.

Source files
------------

// File: rtl/alu4_pkg.sv
// Shared definitions for the round-robin ALU scheduler: opcode encodings and
// the scheduler FSM state type.
package alu4_pkg;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_NOT = 3'd2;
    localparam logic [2:0] ALU_AND = 3'd3;
    localparam logic [2:0] ALU_OR  = 3'd4;
    localparam logic [2:0] ALU_XOR = 3'd5;
    localparam logic [2:0] ALU_CMP = 3'd6;
    localparam logic [2:0] ALU_EQ  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu4_core.sv
// Purely combinational 4-bit ALU: arithmetic, bitwise logic, signed compare
// and equality, with zero/overflow/carry/size flags.
module alu4_core
    import alu4_pkg::*;
(
    input  logic [2:0] op,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] result,
    output logic       zero,
    output logic       overflow,
    output logic       carry,
    output logic       size
);

    logic [4:0] sum_add_s;
    logic [4:0] sum_sub_s;
    logic       ovf_add_s;
    logic       ovf_sub_s;

    // Subtract is a + ~b + 1, so its carry-out reads as "no borrow".
    assign sum_add_s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    assign sum_sub_s = {1'b0, a} + {1'b0, ~b} + 5'd1;
    assign ovf_add_s = (a[3] == b[3]) && (sum_add_s[3] != a[3]);
    assign ovf_sub_s = (a[3] != b[3]) && (sum_sub_s[3] != a[3]);

    // Opcode decode into result and flags.
    always_comb begin
        result   = 4'd0;
        overflow = 1'b0;
        carry    = 1'b0;
        size     = 1'b0;
        case (op)
            ALU_ADD: begin
                result   = sum_add_s[3:0];
                overflow = ovf_add_s;
                carry    = sum_add_s[4];
            end
            ALU_SUB: begin
                result   = sum_sub_s[3:0];
                overflow = ovf_sub_s;
                carry    = sum_sub_s[4];
            end
            ALU_NOT: result = ~a;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_CMP: begin
                result   = sum_sub_s[3:0];
                overflow = ovf_sub_s;
                carry    = sum_sub_s[4];
                size     = ($signed(a) > $signed(b));
            end
            ALU_EQ: begin
                result   = sum_sub_s[3:0];
                overflow = ovf_sub_s;
                carry    = sum_sub_s[4];
                size     = (a == b);
            end
            default: begin
                result   = 4'd0;
                overflow = 1'b0;
                carry    = 1'b0;
                size     = 1'b0;
            end
        endcase
    end

    assign zero = (result == 4'd0);

endmodule

// File: rtl/alu4_sched.sv
// Round-robin arbiter that shares one alu4_core among NREQ requesters and
// returns a registered, requester-tagged result over a valid/ready handshake.
module alu4_sched
    import alu4_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [3*NREQ-1:0] req_op,
    input  logic [4*NREQ-1:0] req_a,
    input  logic [4*NREQ-1:0] req_b,
    input  logic [NREQ-1:0]   req_cin,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [3:0]        rsp_result,
    output logic              rsp_zero,
    output logic              rsp_overflow,
    output logic              rsp_carry,
    output logic              rsp_size
);

    state_t         state_q;
    state_t         state_d;
    logic [IDW-1:0] last_grant_q;
    logic [IDW-1:0] cand_s;
    logic [IDW-1:0] grant_idx_s;
    logic           grant_found_s;
    logic           accept_s;

    logic [2:0]     sel_op_s;
    logic [3:0]     sel_a_s;
    logic [3:0]     sel_b_s;
    logic           sel_cin_s;

    logic [2:0]     op_q;
    logic [3:0]     a_q;
    logic [3:0]     b_q;
    logic           cin_q;
    logic [IDW-1:0] gid_q;

    logic [3:0]     core_result_s;
    logic           core_zero_s;
    logic           core_ovf_s;
    logic           core_carry_s;
    logic           core_size_s;

    logic [IDW-1:0] rsp_id_q;
    logic [3:0]     rsp_result_q;
    logic           rsp_zero_q;
    logic           rsp_ovf_q;
    logic           rsp_carry_q;
    logic           rsp_size_q;

    // Round-robin search: walk from last_grant+1 (wrapping at NREQ), first valid wins.
    always_comb begin
        cand_s        = last_grant_q;
        grant_idx_s   = '0;
        grant_found_s = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand_s = (cand_s == IDW'(NREQ - 1)) ? '0 : cand_s + IDW'(1);
            if (!grant_found_s && req_valid[cand_s]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand_s;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    assign accept_s = (state_q == ST_IDLE) && grant_found_s;

    // Payload mux selecting the winning requester's operands.
    always_comb begin
        sel_op_s  = 3'd0;
        sel_a_s   = 4'd0;
        sel_b_s   = 4'd0;
        sel_cin_s = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == grant_idx_s) begin
                sel_op_s  = req_op[3*i +: 3];
                sel_a_s   = req_a[4*i +: 4];
                sel_b_s   = req_b[4*i +: 4];
                sel_cin_s = req_cin[i];
            end else begin
                sel_cin_s = sel_cin_s;
            end
        end
    end

    alu4_core u_core (
        .op       (op_q),
        .a        (a_q),
        .b        (b_q),
        .cin      (cin_q),
        .result   (core_result_s),
        .zero     (core_zero_s),
        .overflow (core_ovf_s),
        .carry    (core_carry_s),
        .size     (core_size_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; RESP always returns to IDLE before a new grant.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = accept_s ? ST_EXEC : ST_IDLE;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: state_d = rsp_ready ? ST_IDLE : ST_RESP;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: ready only in IDLE and never a function of rsp_ready.
    always_comb begin
        req_ready = '0;
        rsp_valid = 1'b0;
        case (state_q)
            ST_IDLE: req_ready[grant_idx_s] = grant_found_s;
            ST_EXEC: rsp_valid = 1'b0;
            ST_RESP: rsp_valid = 1'b1;
            default: begin
                req_ready = '0;
                rsp_valid = 1'b0;
            end
        endcase
    end

    // Request latch at handshake and result capture in EXEC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= IDW'(NREQ - 1);
            op_q         <= 3'd0;
            a_q          <= 4'd0;
            b_q          <= 4'd0;
            cin_q        <= 1'b0;
            gid_q        <= '0;
            rsp_id_q     <= '0;
            rsp_result_q <= 4'd0;
            rsp_zero_q   <= 1'b0;
            rsp_ovf_q    <= 1'b0;
            rsp_carry_q  <= 1'b0;
            rsp_size_q   <= 1'b0;
        end else begin
            if (accept_s) begin
                last_grant_q <= grant_idx_s;
                gid_q        <= grant_idx_s;
                op_q         <= sel_op_s;
                a_q          <= sel_a_s;
                b_q          <= sel_b_s;
                cin_q        <= sel_cin_s;
            end
            if (state_q == ST_EXEC) begin
                rsp_id_q     <= gid_q;
                rsp_result_q <= core_result_s;
                rsp_zero_q   <= core_zero_s;
                rsp_ovf_q    <= core_ovf_s;
                rsp_carry_q  <= core_carry_s;
                rsp_size_q   <= core_size_s;
            end
        end
    end

    assign rsp_id       = rsp_id_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_zero     = rsp_zero_q;
    assign rsp_overflow = rsp_ovf_q;
    assign rsp_carry    = rsp_carry_q;
    assign rsp_size     = rsp_size_q;

endmodule
